peripheral_sqrt_param: RTL and testbench
========================================

// Module: peripheral_sqrt_param
// PURPOSE
//  Memory-mapped integer square-root peripheral with a parametrised radicand width.
//  Sits on the SoC peripheral bus (cs/addr/rd/wr, 32-bit data).
//  Contains its own iterative digit-by-digit (restoring) root engine: one result bit per clock.
//  Adds busy/overrun status, sticky done with read-to-clear, and an interrupt output.
// PARAMETERS
//  WIDTH  16  radicand width in bits; even, 2..32; root = WIDTH/2 bits, remainder = WIDTH/2+1 bits
// PORTS
//  clk       in   1   system clock; single clock domain
//  rst       in   1   synchronous, active-high reset
//  d_in      in   32  write data
//  cs        in   1   peripheral select
//  addr      in   5   register byte address
//  rd        in   1   read strobe (valid with cs)
//  wr        in   1   write strobe (valid with cs)
//  d_out     out  32  registered read data
//  done_irq  out  1   done & irq_en, level
// BEHAVIOUR
//  Register map (unlisted addr: writes ignored, reads return 0):
//   0x04 RADICAND  RW  d_in[WIDTH-1:0]; upper bits read 0
//   0x08 CTRL      W bit0=start (self-clearing strobe, reads 0); RW bit1=irq_en
//   0x0C REMAINDER RO  zero-extended, WIDTH/2+1 bits
//   0x10 ROOT      RO  zero-extended, WIDTH/2 bits
//   0x14 STATUS    RO  bit0=done(sticky), bit1=busy, bit2=overrun(sticky)
//  Reset: d_out=0, RADICAND=0, irq_en=0, ROOT=0, REMAINDER=0, done=0, busy=0, overrun=0,
//   FSM=IDLE. Reset mid-operation aborts immediately; no result is kept.
//  Write: takes effect at the posedge where cs&&wr; d_in is sampled at that edge.
//  Read: at the posedge where cs&&rd, d_out <= the selected register; otherwise d_out holds.
//   Data is visible one cycle after the strobe.
//  FSM IDLE:
//   A CTRL write with d_in[0]=1 is a start.
//   At that edge: snapshot RADICAND into a shift register; clear rem, root and done; iter=WIDTH/2.
//   Go to RUN with busy=1.
//   The same CTRL write also updates irq_en from d_in[1].
//  FSM RUN:
//   Each cycle: r2 = {rem, sh[WIDTH-1:WIDTH-2]}; sh <<= 2; t = {root, 2'b01}.
//   If r2 >= t: rem = r2 - t and root = {root, 1}; else rem = r2 and root = {root, 0}.
//   iter decrements every cycle.
//   On the last iteration edge: ROOT and REMAINDER update, done=1, busy=0, go to IDLE.
//  Latency: start accepted at edge k; done=1 and results valid after edge k+WIDTH/2.
//   For WIDTH=16 that is 8 cycles.
//  ROOT/REMAINDER hold the last completed result until the next completion or reset.
//   They are not updated mid-RUN.
//  Boundary conditions:
//   - Start while busy: ignored; the in-flight operation is unaffected; overrun=1 (sticky).
//   - RADICAND write while busy: the register updates, but the in-flight snapshot is unaffected.
//   - STATUS read: returns the pre-edge value, then clears done and overrun at the same edge.
//   - Completion and STATUS read on the same edge: the read returns done=0; done ends at 1 (set wins).
//   - Start while done=1: done clears at the start edge.
//   - rd and wr together on the same address: both act; the read returns the pre-write value.
//   - cs=0: rd/wr are ignored; the engine keeps running.
// TESTING (WIDTH=16 unless noted; run: write RADICAND, write CTRL=1, poll STATUS)
//  1. RADICAND=144 -> exactly 8 cycles after start: ROOT=12, REMAINDER=0, STATUS=0x1.
//     Next STATUS read = 0x0.
//  2. RADICAND=0xFFFF -> ROOT=255, REMAINDER=510.
//     RADICAND=0 -> ROOT=0, REMAINDER=0.
//     RADICAND=17 -> ROOT=4, REMAINDER=1.
//  3. Start 17, then at cycle 3 write RADICAND=144 and CTRL=1 -> result is 4/1, STATUS=0x5.
//     Next start computes 12/0.
//  4. CTRL=0x3 with RADICAND=100 -> done_irq rises with done (ROOT=10).
//     A STATUS read drops done_irq the next cycle.
//  5. Assert rst at cycle 4 of a run -> all registers read 0, busy=0, done never set.
//     A new start then completes normally.
//  6. WIDTH=32: RADICAND=0xFFFFFFFF -> ROOT=65535, REMAINDER=131070 after 16 cycles.
//     Random sweep vs. reference: root^2 + rem == x and rem <= 2*root.

Source files
------------

// File: rtl/peripheral_sqrt_param.sv
// Memory-mapped integer square-root peripheral: bus register file plus an iterative
// restoring root engine that produces one root bit per clock.
module peripheral_sqrt_param #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        done_irq
);

    localparam int HALF = WIDTH / 2;
    localparam int IW   = $clog2(HALF + 1);

    localparam logic [4:0] ADDR_RADICAND  = 5'h04;
    localparam logic [4:0] ADDR_CTRL      = 5'h08;
    localparam logic [4:0] ADDR_REMAINDER = 5'h0C;
    localparam logic [4:0] ADDR_ROOT      = 5'h10;
    localparam logic [4:0] ADDR_STATUS    = 5'h14;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] radicand_reg;
    logic             irq_en_reg;
    logic [HALF-1:0]  root_reg;
    logic [HALF:0]    rem_reg;
    logic             done_reg;
    logic             overrun_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [HALF:0]    work_rem_reg;
    logic [HALF-1:0]  work_root_reg;
    logic [IW-1:0]    iter_reg;

    logic             busy;
    logic             wr_en;
    logic             rd_en;
    logic             start;
    logic             status_rd;
    logic             last_iter;
    logic [31:0]      rd_data;

    logic [HALF+2:0]  r2;
    logic [HALF+2:0]  t;
    logic [HALF+2:0]  diff;
    logic             ge;
    logic [HALF:0]    rem_next;
    logic [HALF:0]    root_shift;
    logic [HALF-1:0]  root_next;

    // Upper write-data bits are unused when WIDTH < 32.
    logic unused_din;
    assign unused_din = ^d_in;

    assign busy      = (state_reg == ST_RUN);
    assign wr_en     = cs && wr;
    assign rd_en     = cs && rd;
    assign start     = wr_en && (addr == ADDR_CTRL) && d_in[0];
    assign status_rd = rd_en && (addr == ADDR_STATUS);
    assign last_iter = busy && (iter_reg == IW'(1));
    assign done_irq  = done_reg && irq_en_reg;

    // One restoring step: bring down two radicand bits, try subtracting {root, 01}.
    always_comb begin
        r2         = {work_rem_reg, sh_reg[WIDTH-1 -: 2]};
        t          = {1'b0, work_root_reg, 2'b01};
        ge         = (r2 >= t);
        diff       = r2 - t;
        rem_next   = ge ? diff[HALF:0] : r2[HALF:0];
        root_shift = {work_root_reg, ge};
        root_next  = root_shift[HALF-1:0];
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            ADDR_RADICAND:  rd_data = 32'(radicand_reg);
            ADDR_CTRL:      rd_data = {30'd0, irq_en_reg, 1'b0};
            ADDR_REMAINDER: rd_data = 32'(rem_reg);
            ADDR_ROOT:      rd_data = 32'(root_reg);
            ADDR_STATUS:    rd_data = {29'd0, overrun_reg, busy, done_reg};
            default:        rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            d_out         <= 32'd0;
            radicand_reg  <= '0;
            irq_en_reg    <= 1'b0;
            root_reg      <= '0;
            rem_reg       <= '0;
            done_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            sh_reg        <= '0;
            work_rem_reg  <= '0;
            work_root_reg <= '0;
            iter_reg      <= '0;
        end else begin
            if (rd_en) begin
                d_out <= rd_data;
            end
            if (wr_en && addr == ADDR_RADICAND) begin
                radicand_reg <= d_in[WIDTH-1:0];
            end
            if (wr_en && addr == ADDR_CTRL) begin
                irq_en_reg <= d_in[1];
            end
            // Read-to-clear first; set assignments further down take priority.
            if (status_rd) begin
                done_reg    <= 1'b0;
                overrun_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sh_reg        <= radicand_reg;
                        work_rem_reg  <= '0;
                        work_root_reg <= '0;
                        iter_reg      <= IW'(HALF);
                        done_reg      <= 1'b0;
                        state_reg     <= ST_RUN;
                    end
                end
                default: begin
                    sh_reg        <= sh_reg << 2;
                    work_rem_reg  <= rem_next;
                    work_root_reg <= root_next;
                    iter_reg      <= iter_reg - IW'(1);
                    if (start) begin
                        overrun_reg <= 1'b1;
                    end
                    if (last_iter) begin
                        root_reg  <= root_next;
                        rem_reg   <= rem_next;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_sqrt_param.sv
// Bench for peripheral_sqrt_param: a WIDTH=16 and a WIDTH=32 instance share one bus;
// results are compared against a binary-search integer square-root model.
module tb_peripheral_sqrt_param;

    localparam logic [4:0] A_RAD    = 5'h04;
    localparam logic [4:0] A_CTRL   = 5'h08;
    localparam logic [4:0] A_REM    = 5'h0C;
    localparam logic [4:0] A_ROOT   = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] d_in = 32'd0;
    logic [31:0] d_out16;
    logic [31:0] d_out32;
    logic        irq16;
    logic        irq32;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    peripheral_sqrt_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out16), .done_irq(irq16)
    );

    peripheral_sqrt_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out32), .done_irq(irq32)
    );

    function automatic longint ref_root(input longint x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // All bus tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] q16, output logic [31:0] q32);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        q16 = d_out16; q32 = d_out32;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic poll_done(input bit wide, output logic [31:0] st, output int n);
        logic [31:0] a, b;
        n = 0;
        st = 32'd0;
        do begin
            read_reg(A_STATUS, a, b);
            st = wide ? b : a;
            n++;
        end while (!st[0] && n < 60);
        total_cnt++;
        if (!st[0]) $display("FAIL poll_timeout: status=%h after %0d reads, required done=1", st, n);
        else pass_cnt++;
    endtask

    task automatic run_sqrt(input logic [31:0] x, input bit wide, output logic [31:0] root,
                            output logic [31:0] rem, output logic [31:0] st, output int n);
        logic [31:0] a, b;
        write_reg(A_RAD, x);
        write_reg(A_CTRL, 32'd1);
        poll_done(wide, st, n);
        read_reg(A_ROOT, a, b);
        root = wide ? b : a;
        read_reg(A_REM, a, b);
        rem = wide ? b : a;
        $display("run w=%0d x=%h root=%0d rem=%0d status=%h polls=%0d", wide ? 32 : 16, x, root, rem, st, n);
    endtask

    task automatic test_reset();
        logic [31:0] a, b;
        logic [4:0] addrs [5];
        addrs = '{A_RAD, A_CTRL, A_REM, A_ROOT, A_STATUS};
        pulse_reset();
        total_cnt++;
        if (d_out16 !== 32'd0 || d_out32 !== 32'd0 || irq16 !== 1'b0 || irq32 !== 1'b0)
            $display("FAIL reset_outputs: d_out16=%h d_out32=%h irq=%b%b, required all 0", d_out16, d_out32, irq16, irq32);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            read_reg(addrs[i], a, b);
            total_cnt++;
            if (a !== 32'd0 || b !== 32'd0)
                $display("FAIL reset_reg_%h: got %h/%h, required 0", addrs[i], a, b);
            else pass_cnt++;
        end
    endtask

    task automatic test_exact_latency();
        logic [31:0] a, b;
        write_reg(A_RAD, 32'd144);
        write_reg(A_CTRL, 32'd1);
        // Reads sample the pre-edge value, so the 8th read still sees busy.
        for (int i = 1; i <= 8; i++) begin
            read_reg(A_STATUS, a, b);
            total_cnt++;
            if (a !== 32'h2) $display("FAIL latency_busy_%0d: status=%h, required 2", i, a);
            else pass_cnt++;
        end
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'h1) $display("FAIL latency_done: status=%h, required 1", a);
        else pass_cnt++;
        read_reg(A_ROOT, a, b);
        total_cnt++;
        if (a !== 32'd12) $display("FAIL root_144: got %0d, required 12", a);
        else pass_cnt++;
        read_reg(A_REM, a, b);
        total_cnt++;
        if (a !== 32'd0) $display("FAIL rem_144: got %0d, required 0", a);
        else pass_cnt++;
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'h0) $display("FAIL status_clear: status=%h, required 0", a);
        else pass_cnt++;
    endtask

    task automatic test_known_values();
        logic [31:0] xs [3];
        logic [31:0] r, m, st;
        int n;
        xs = '{32'hFFFF, 32'd0, 32'd17};
        for (int i = 0; i < 3; i++) begin
            longint x = longint'(xs[i]);
            longint er = ref_root(x);
            run_sqrt(xs[i], 1'b0, r, m, st, n);
            total_cnt++;
            if (r !== 32'(er) || m !== 32'(x - er * er) || st !== 32'h1 || n != 9)
                $display("FAIL known_%0d: root=%0d rem=%0d st=%h polls=%0d, required %0d/%0d st=1 polls=9",
                         x, r, m, st, n, er, x - er * er);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        logic [31:0] a, b, r, m, st;
        int n;
        write_reg(A_RAD, 32'd17);
        write_reg(A_CTRL, 32'd1);
        idle(1);
        write_reg(A_RAD, 32'd144);
        write_reg(A_CTRL, 32'd1);
        idle(8);
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'h5) $display("FAIL overrun_status: status=%h, required 5", a);
        else pass_cnt++;
        read_reg(A_ROOT, a, b);
        read_reg(A_REM, r, b);
        total_cnt++;
        if (a !== 32'd4 || r !== 32'd1) $display("FAIL overrun_result: %0d/%0d, required 4/1", a, r);
        else pass_cnt++;
        read_reg(A_RAD, a, b);
        total_cnt++;
        if (a !== 32'd144) $display("FAIL radicand_busy_write: got %0d, required 144", a);
        else pass_cnt++;
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'h0) $display("FAIL overrun_clear: status=%h, required 0", a);
        else pass_cnt++;
        write_reg(A_CTRL, 32'd1);
        poll_done(1'b0, st, n);
        read_reg(A_ROOT, r, b);
        read_reg(A_REM, m, b);
        total_cnt++;
        if (r !== 32'd12 || m !== 32'd0 || st !== 32'h1)
            $display("FAIL after_overrun: %0d/%0d st=%h, required 12/0 st=1", r, m, st);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] a, b;
        int n;
        write_reg(A_RAD, 32'd100);
        write_reg(A_CTRL, 32'd3);
        total_cnt++;
        if (irq16 !== 1'b0) $display("FAIL irq_at_start: irq=%b, required 0", irq16);
        else pass_cnt++;
        n = 0;
        while (irq16 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != 8) $display("FAIL irq_latency: rose after %0d cycles, required 8", n);
        else pass_cnt++;
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'h1 || irq16 !== 1'b0)
            $display("FAIL irq_clear: status=%h irq=%b, required status 1 irq 0", a, irq16);
        else pass_cnt++;
        read_reg(A_ROOT, a, b);
        total_cnt++;
        if (a !== 32'd10) $display("FAIL root_100: got %0d, required 10", a);
        else pass_cnt++;
        read_reg(A_CTRL, a, b);
        total_cnt++;
        if (a !== 32'h2) $display("FAIL ctrl_read: got %h, required 2", a);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] a, b, r, m, st;
        logic [4:0] addrs [5];
        int n;
        addrs = '{A_RAD, A_CTRL, A_REM, A_ROOT, A_STATUS};
        write_reg(A_RAD, 32'd200);
        write_reg(A_CTRL, 32'd3);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            read_reg(addrs[i], a, b);
            total_cnt++;
            if (a !== 32'd0) $display("FAIL midrst_reg_%h: got %h, required 0", addrs[i], a);
            else pass_cnt++;
        end
        idle(12);
        read_reg(A_STATUS, a, b);
        total_cnt++;
        if (a !== 32'd0 || irq16 !== 1'b0) $display("FAIL midrst_no_done: status=%h irq=%b, required 0", a, irq16);
        else pass_cnt++;
        run_sqrt(32'd50, 1'b0, r, m, st, n);
        total_cnt++;
        if (r !== 32'd7 || m !== 32'd1 || st !== 32'h1)
            $display("FAIL midrst_restart: %0d/%0d st=%h, required 7/1 st=1", r, m, st);
        else pass_cnt++;
    endtask

    task automatic test_bus_rules();
        logic [31:0] a, b;
        write_reg(5'h00, 32'hFFFF_FFFF);
        read_reg(5'h00, a, b);
        total_cnt++;
        if (a !== 32'd0 || b !== 32'd0) $display("FAIL unmapped_00: got %h/%h, required 0", a, b);
        else pass_cnt++;
        read_reg(5'h1C, a, b);
        total_cnt++;
        if (a !== 32'd0) $display("FAIL unmapped_1c: got %h, required 0", a);
        else pass_cnt++;
        write_reg(A_RAD, 32'hDEAD_BEEF);
        read_reg(A_RAD, a, b);
        total_cnt++;
        if (a !== 32'h0000_BEEF || b !== 32'hDEAD_BEEF)
            $display("FAIL radicand_width: got %h/%h, required 0000beef/deadbeef", a, b);
        else pass_cnt++;
        write_reg(A_RAD, 32'h1234);
        cs = 1'b0; wr = 1'b1; addr = A_RAD; d_in = 32'h5555;
        @(negedge clk);
        wr = 1'b0;
        read_reg(A_RAD, a, b);
        total_cnt++;
        if (a !== 32'h1234) $display("FAIL cs_low_write: got %h, required 1234", a);
        else pass_cnt++;
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_RAD; d_in = 32'h00AB;
        @(negedge clk);
        a = d_out16;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        total_cnt++;
        if (a !== 32'h1234) $display("FAIL rdwr_pre_value: got %h, required 1234", a);
        else pass_cnt++;
        read_reg(A_RAD, a, b);
        idle(3);
        total_cnt++;
        if (a !== 32'hAB || d_out16 !== 32'hAB) $display("FAIL rdwr_post_hold: got %h then %h, required ab", a, d_out16);
        else pass_cnt++;
    endtask

    task automatic test_random_sweep16();
        logic [31:0] r, m, st, d;
        int n;
        for (int i = 0; i < 12; i++) begin
            longint x, er;
            d = $urandom;
            x = longint'(d[15:0]);
            er = ref_root(x);
            run_sqrt(d, 1'b0, r, m, st, n);
            total_cnt++;
            if (r !== 32'(er) || m !== 32'(x - er * er) || st !== 32'h1 ||
                longint'(r) * longint'(r) + longint'(m) != x || longint'(m) > 2 * longint'(r))
                $display("FAIL sweep16 x=%0d: %0d/%0d st=%h, required %0d/%0d st=1", x, r, m, st, er, x - er * er);
            else pass_cnt++;
        end
    endtask

    task automatic test_wide();
        logic [31:0] r, m, st, d;
        int n;
        pulse_reset();
        run_sqrt(32'hFFFF_FFFF, 1'b1, r, m, st, n);
        total_cnt++;
        if (r !== 32'd65535 || m !== 32'd131070 || st !== 32'h1 || n != 17)
            $display("FAIL wide_max: %0d/%0d st=%h polls=%0d, required 65535/131070 st=1 polls=17", r, m, st, n);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            longint x, er;
            d = (i == 0) ? 32'd1 : $urandom;
            x = longint'(d);
            er = ref_root(x);
            run_sqrt(d, 1'b1, r, m, st, n);
            total_cnt++;
            if (r !== 32'(er) || m !== 32'(x - er * er) ||
                longint'(r) * longint'(r) + longint'(m) != x || longint'(m) > 2 * longint'(r))
                $display("FAIL sweep32 x=%0d: %0d/%0d, required %0d/%0d", x, r, m, er, x - er * er);
            else pass_cnt++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_exact_latency();
        test_known_values();
        test_overrun();
        test_irq();
        test_reset_mid_run();
        test_bus_rules();
        test_random_sweep16();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
